// File: rtl/clkmeter_pkg.sv
// Shared types and elaboration-time helpers for the clkmeter strobe-rate meter.
package clkmeter_pkg;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        GATE = 1'b1
    } clkmeter_state_t;

    function automatic int clkmeter_expected(int from, int rate, int window);
        return int'((longint'(rate) * longint'(window)) / longint'(from));
    endfunction

    function automatic int clkmeter_width(int window);
        return $clog2(window + 1);
    endfunction

endpackage

// File: rtl/clkmeter_sync.sv
// Two-flop synchronizer for an asynchronous strobe; instantiated by clkmeter only
// when CLKMETER_SYNC_EN is defined.
module clkmeter_sync (
    input  logic clock,
    input  logic reset,
    input  logic d_i,
    output logic q_o
);
    logic meta_q;
    logic sync_q;

    // Metastability filter: two back-to-back flops cleared by reset.
    always_ff @(posedge clock) begin
        if (reset) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/clkmeter.sv
// Strobe-rate meter: counts strobe rising edges over back-to-back gate windows and
// publishes count/lock/ovf with a valid/ack handshake. CLKMETER_SYNC_EN adds an input synchronizer.
module clkmeter
    import clkmeter_pkg::*;
#(
    parameter int  From      = 50000000,
    parameter int  Rate      = 1000000,
    parameter int  Window    = 1024,
    parameter int  Tolerance = 1,
    localparam int Width     = clkmeter_width(Window)
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             ckena,
    input  logic             strobe,
    output logic [Width-1:0] count,
    output logic             valid,
    input  logic             ack,
    output logic             lock,
    output logic             ovf,
    output logic             lost
);
    localparam int               Expected = clkmeter_expected(From, Rate, Window);
    localparam logic [Width-1:0] AccMax   = {Width{1'b1}};
    localparam logic [Width-1:0] LastGate = Width'(Window - 1);

    logic             strobe_s;
    logic             edge_s;
    logic             publish_s;
    int               diff_s;
    logic [Width-1:0] acc_d;
    logic             sat_d;
    logic             lock_d;

    clkmeter_state_t  state_q;
    logic             strobe_q;
    logic [Width-1:0] acc_q;
    logic [Width-1:0] gcnt_q;
    logic             sat_q;
    logic [Width-1:0] count_q;
    logic             valid_q;
    logic             lock_q;
    logic             ovf_q;
    logic             lost_q;

`ifdef CLKMETER_SYNC_EN
    clkmeter_sync u_sync (
        .clock (clock),
        .reset (reset),
        .d_i   (strobe),
        .q_o   (strobe_s)
    );
`else
    assign strobe_s = strobe;
`endif

    assign edge_s    = strobe_s & ~strobe_q;
    assign publish_s = (state_q == GATE) && ckena && (gcnt_q == LastGate);

    // Accumulator next value including this cycle's edge, with saturation and lock compare.
    always_comb begin
        acc_d  = acc_q;
        sat_d  = sat_q;
        lock_d = 1'b0;
        diff_s = 0;
        if (edge_s) begin
            if (acc_q == AccMax) begin
                sat_d = 1'b1;
            end else begin
                acc_d = acc_q + Width'(1'b1);
            end
        end else begin
            acc_d = acc_q;
        end
        diff_s = int'(acc_d) - Expected;
        lock_d = (diff_s <= Tolerance) && (diff_s >= -Tolerance);
    end

    // Gate FSM, accumulator, published result and handshake flags.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q  <= IDLE;
            strobe_q <= 1'b0;
            acc_q    <= {Width{1'b0}};
            gcnt_q   <= {Width{1'b0}};
            sat_q    <= 1'b0;
            count_q  <= {Width{1'b0}};
            valid_q  <= 1'b0;
            lock_q   <= 1'b0;
            ovf_q    <= 1'b0;
            lost_q   <= 1'b0;
        end else begin
            strobe_q <= strobe_s;
            case (state_q)
                IDLE: begin
                    acc_q  <= {Width{1'b0}};
                    gcnt_q <= {Width{1'b0}};
                    sat_q  <= 1'b0;
                    if (ckena) begin
                        state_q <= GATE;
                    end
                end
                GATE: begin
                    if (!ckena) begin
                        state_q <= IDLE;
                        acc_q   <= {Width{1'b0}};
                        gcnt_q  <= {Width{1'b0}};
                        sat_q   <= 1'b0;
                    end else if (gcnt_q == LastGate) begin
                        count_q <= acc_d;
                        lock_q  <= lock_d;
                        ovf_q   <= sat_d;
                        acc_q   <= {Width{1'b0}};
                        gcnt_q  <= {Width{1'b0}};
                        sat_q   <= 1'b0;
                    end else begin
                        acc_q  <= acc_d;
                        sat_q  <= sat_d;
                        gcnt_q <= gcnt_q + Width'(1'b1);
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
            // A coincident ack consumes the old result; the new one stays pending.
            if (publish_s) begin
                valid_q <= 1'b1;
                if (valid_q && !ack) begin
                    lost_q <= 1'b1;
                end
            end else if (ack && valid_q) begin
                valid_q <= 1'b0;
                lost_q  <= 1'b0;
            end
        end
    end

    assign count = count_q;
    assign valid = valid_q;
    assign lock  = lock_q;
    assign ovf   = ovf_q;
    assign lost  = lost_q;

endmodule

// File: doc/clkmeter.md
# clkmeter

Strobe-rate meter: counts rising edges of a strobe input (typically a `clkdiv` `ckout`) over a fixed gate window of system clocks and publishes the count with a valid/ack handshake and a lock flag against an expected rate. It is the receiving end of the clock-enable interface: `clkdiv` generates strobes at `DownTo` from `From`, and `clkmeter` checks them. It sits beside divider instances for self-check and status reporting.

## Interface
- `From`, 50000000, system clock frequency in Hz.
- `Rate`, 1000000, expected strobe rate in Hz.
- `Window`, 1024, gate length in clocks; must be ≥ 2.
- `Tolerance`, 1, allowed |count − Expected| for lock.
- Derived: `Expected = (Rate*Window)/From`, floor, computed at elaboration. `Width = $clog2(Window+1)`.

Ports:
- `clock` in 1: system clock, rising edge.
- `reset` in 1: synchronous, active-high.
- `ckena` in 1: meter enable; low aborts or holds off measurement.
- `strobe` in 1: strobe under test, level, sampled each clock.
- `count` out Width: last published edge count.
- `valid` out 1: result pending; held until acked.
- `ack` in 1: consumer accepts the result.
- `lock` out 1: `|count − Expected| ≤ Tolerance`, registered with `count`.
- `ovf` out 1: last published window saturated.
- `lost` out 1: sticky; an unacked result was overwritten.

## Operation
- Edge detect: `edge = strobe & ~strobe_q`. `strobe_q` updates every cycle in every state and resets to 0.
- FSM states:
  - IDLE: counters cleared. If `ckena` = 1, go to GATE; the transition cycle is not a gate cycle.
  - GATE: each cycle, `acc += edge` and `gcnt++`.
  - On the cycle with `gcnt == Window-1`:
    - publish `count <= sat(acc + edge)`, plus `lock` and `ovf`.
    - clear `acc` and `gcnt`; stay in GATE so windows run back-to-back with no gap cycles.
  - In GATE, `ckena` = 0 → IDLE the next cycle: discard the partial window; `count`, `valid`, `lock` unchanged.
- Saturation: `acc` stops at 2^Width−1; `ovf` = 1 for that result. It is unreachable with one edge per two cycles, but must be present.
- Handshake:
  - Publish sets `valid`. `ack` while `valid` clears it.
  - `ack` while `valid` = 0 is ignored.
  - Publish and `ack` in the same cycle: the new result is taken, `valid` stays 1, `lost` unchanged.
  - Publish while `valid` = 1 without `ack`: overwrite and set `lost`.
  - `lost` clears only on `reset` or an `ack` that does not coincide with a publish.
- Reset, from any state: all outputs 0, FSM → IDLE, `acc`/`gcnt`/`strobe_q` = 0.
- `reset` takes priority over `ckena`, `ack`, and a publish in the same cycle.

## Timing
- First window: `ckena` rises in cycle t → gate cycles t+1 … t+Window.
- Result registered at the end of cycle t+Window; `valid` is high from cycle t+Window+1.
- Steady state: one publish every `Window` clocks.
- Edge-to-`acc` latency: 0 cycles. An edge on the final gate cycle counts in the closing window.
- Edges in IDLE cycles are not counted, but they do update `strobe_q`.

## Configuration
- `CLKMETER_SYNC_EN` defined:
  - `strobe` passes through a two-flop synchronizer (reset 0) before edge detect, for asynchronous sources.
  - All edge-to-count paths gain 2 cycles. Window boundaries are unchanged.
- Undefined: `strobe` is used directly and must be synchronous to `clock`.

## Structure
- `clkmeter_pkg`:
  - state enum `clkmeter_state_t {IDLE, GATE}`.
  - function `clkmeter_expected(from, rate, window)`.
  - function `clkmeter_width(window)`.
- Sub-module `clkmeter_sync`: two-flop synchronizer, instantiated only under `CLKMETER_SYNC_EN`.
- Edge detect, FSM, accumulator and handshake live in `clkmeter`.

## Test plan
- `From`=64, `Rate`=16, `Window`=64, `strobe` 1-cycle high every 4 clocks, `ckena`=1, `ack` each `valid` → `count`=16, `lock`=1 every 64 clocks, `ovf`=`lost`=0.
- Same config, strobe every 5 clocks (12 or 13 edges/window), `Tolerance`=1 → `lock`=0, since |12−16| and |13−16| both exceed 1.
- `strobe` held high for a whole window → `count`=0 after the first window; a single edge on the last gate cycle → `count`=1 in that window.
- Never `ack` across two windows → second publish sets `lost`=1, `count`=latest. `ack` coincident with a publish → `valid`=1, `lost` unchanged.
- Drop `ckena` at gate cycle 30 → IDLE, no publish, prior `count` kept. Re-raise `ckena` → full fresh window. `reset` mid-window → all outputs 0 next cycle.
- With `CLKMETER_SYNC_EN`: the first-window edge count is shifted by the 2-cycle pipeline (edges from the window's last 2 cycles land in the next window); the steady-state count matches the non-sync build.
